attention_score_seq: RTL and testbench

ATTENTION_SCORE_SEQ -- requirements
Module: attention_score_seq

---
 rtl/attention_score_seq.sv | 212 +++++++++++++++++++++
 tb/tb_attention_score_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attention_score_seq.sv
// -----------------------------------------------------------------------------
// attention_score_seq
//
// Sequencer for one attention-score step. It does three things in order:
//   1. Kicks the transpose engine so that it builds K^T in its B buffer.
//   2. Copies K^T element by element from the transpose-B read port into
//      the X SRAM. The copy is row-major over (k, n), with k < D_len and
//      n < T, and only one read is outstanding at any time.
//   3. Kicks the GEMM engine and waits for it to complete.
//
// A start request whose D_len is outside 1..DMAX is rejected with a
// one-cycle err pulse, and the sequencer stays idle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, abort        request a sequence / abandon the running sequence
//   D_len               head dimension, latched when start is accepted
//   busy, done, err     status: busy while not idle, done and err are
//                       one-cycle pulses
//   tr_start            transpose kick
//   tr_busy, tr_done    transpose handshake inputs
//   tr_b_re             transpose-B read strobe
//   tr_b_row, tr_b_col  transpose-B read address
//   tr_b_rdata          transpose-B read data
//   tr_b_rvalid         transpose-B read data valid
//   x_we                X SRAM write strobe
//   x_k, x_n            X SRAM write address
//   x_wdata, x_wmask    X SRAM write data and byte mask
//   gemm_start          GEMM kick
//   gemm_busy, gemm_done  GEMM handshake inputs
// -----------------------------------------------------------------------------
module attention_score_seq #(
  parameter int T      = 4,
  parameter int DMAX   = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int T_W    = (T > 1) ? $clog2(T) : 1,
  parameter int D_W    = (DMAX > 1) ? $clog2(DMAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       D_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              tr_start,
  input  logic              tr_busy,
  input  logic              tr_done,
  output logic              tr_b_re,
  output logic [31:0]       tr_b_row,
  output logic [31:0]       tr_b_col,
  input  logic [DATA_W-1:0] tr_b_rdata,
  input  logic              tr_b_rvalid,
  output logic              x_we,
  output logic [D_W-1:0]    x_k,
  output logic [T_W-1:0]    x_n,
  output logic [DATA_W-1:0] x_wdata,
  output logic [BYTE_W-1:0] x_wmask,
  output logic              gemm_start,
  input  logic              gemm_busy,
  input  logic              gemm_done
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_TR_KICK   = 4'd1;
  localparam logic [3:0] S_TR_WAIT   = 4'd2;
  localparam logic [3:0] S_RD_REQ    = 4'd3;
  localparam logic [3:0] S_RD_WAIT   = 4'd4;
  localparam logic [3:0] S_WR_X      = 4'd5;
  localparam logic [3:0] S_GEMM_KICK = 4'd6;
  localparam logic [3:0] S_GEMM_WAIT = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam logic [T_W-1:0] N_LAST = T_W'(T - 1);
  localparam logic [15:0]    D_MAX  = 16'(DMAX);

  logic [3:0]     state;
  logic [3:0]     state_nxt;
  logic [D_W-1:0] k;
  logic [D_W-1:0] k_nxt;
  logic [T_W-1:0] n;
  logic [T_W-1:0] n_nxt;
  logic [15:0]    d_len_q;
  logic           d_len_ok;
  logic           accept;
  logic           reject;
  logic           last_elem;

  // A start is only looked at in IDLE. The head dimension must lie in
  // 1..DMAX; any other value is refused without leaving IDLE.
  assign d_len_ok  = (D_len != 16'd0) && (D_len <= D_MAX);
  assign accept    = (state == S_IDLE) && start && d_len_ok;
  assign reject    = (state == S_IDLE) && start && !d_len_ok;

  // The copy finishes on the element (D_len-1, T-1). The comparison uses
  // the latched D_len, so later changes on the D_len input have no effect.
  assign last_elem = (16'(k) == (d_len_q - 16'd1)) && (n == N_LAST);

  // Next-state logic. Each handshake state waits for its level or pulse
  // from the partner engine. An abort in any non-idle state overrides
  // every other transition and returns the sequencer to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept)      state_nxt = S_TR_KICK;
      S_TR_KICK:   if (tr_busy)     state_nxt = S_TR_WAIT;
      S_TR_WAIT:   if (tr_done)     state_nxt = S_RD_REQ;
      S_RD_REQ:                     state_nxt = S_RD_WAIT;
      S_RD_WAIT:   if (tr_b_rvalid) state_nxt = S_WR_X;
      S_WR_X:      state_nxt = last_elem ? S_GEMM_KICK : S_RD_REQ;
      S_GEMM_KICK: if (gemm_busy)   state_nxt = S_GEMM_WAIT;
      S_GEMM_WAIT: if (gemm_done)   state_nxt = S_DONE;
      S_DONE:                       state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  // Element counters. They are cleared when a start is accepted and again
  // when the copy begins. They step row-major after each X write: n runs
  // fastest and wraps at T-1 into the next k. The read address for the next
  // element is taken from k_nxt/n_nxt, so it is ready in the same cycle that
  // RD_REQ is entered.
  always_comb begin
    k_nxt = k;
    n_nxt = n;
    if (accept || ((state == S_TR_WAIT) && tr_done)) begin
      k_nxt = '0;
      n_nxt = '0;
    end else if (state == S_WR_X) begin
      if (n == N_LAST) begin
        n_nxt = '0;
        k_nxt = k + D_W'(1);
      end else begin
        n_nxt = n + T_W'(1);
      end
    end
  end

  // State, counters and the latched head dimension.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      n       <= '0;
      d_len_q <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      n     <= n_nxt;
      if (accept) begin
        d_len_q <= D_len;
      end
    end
  end

  // Strobe outputs are registered from the next state. Each strobe is
  // therefore high exactly during the cycles the sequencer spends in the
  // matching state. An abort forces the next state to IDLE, so every strobe
  // drops on the following cycle. err is the only strobe that is not tied
  // to a state: it marks a refused start.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tr_start   <= 1'b0;
      tr_b_re    <= 1'b0;
      x_we       <= 1'b0;
      gemm_start <= 1'b0;
    end else begin
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      err        <= reject;
      tr_start   <= (state_nxt == S_TR_KICK);
      tr_b_re    <= (state_nxt == S_RD_REQ);
      x_we       <= (state_nxt == S_WR_X);
      gemm_start <= (state_nxt == S_GEMM_KICK);
    end
  end

  // Address and data outputs are loaded only when their strobe is about to
  // rise, and they hold that value afterwards. The read word is captured
  // straight into x_wdata on the valid cycle in RD_WAIT. A valid seen in
  // any other state never reaches this register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tr_b_row <= '0;
      tr_b_col <= '0;
      x_k      <= '0;
      x_n      <= '0;
      x_wdata  <= '0;
      x_wmask  <= '0;
    end else begin
      if (state_nxt == S_RD_REQ) begin
        tr_b_row <= 32'(k_nxt);
        tr_b_col <= 32'(n_nxt);
      end
      if (state_nxt == S_WR_X) begin
        x_k     <= k;
        x_n     <= n;
        x_wdata <= tr_b_rdata;
        x_wmask <= '1;
      end
    end
  end

endmodule

// File: tb/tb_attention_score_seq.sv
// -----------------------------------------------------------------------------
// tb_attention_score_seq
//
// Drives attention_score_seq against three behavioural partner models:
//   - a transpose engine,
//   - a transpose-B read port that returns salt + row*16 + col,
//   - a GEMM engine.
// Each model has configurable response delays. A monitor records every X
// write and counts strobe cycles. The expected write list, strobe counts and
// busy duration come from the sequence rules, computed with plain
// arithmetic.
// -----------------------------------------------------------------------------
module tb_attention_score_seq;

  localparam int T      = 4;
  localparam int DMAX   = 8;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 4;
  localparam int T_W    = 2;
  localparam int D_W    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [15:0]       D_len;
  logic              busy;
  logic              done;
  logic              err;
  logic              tr_start;
  logic              tr_busy;
  logic              tr_done;
  logic              tr_b_re;
  logic [31:0]       tr_b_row;
  logic [31:0]       tr_b_col;
  logic [DATA_W-1:0] tr_b_rdata;
  logic              tr_b_rvalid;
  logic              x_we;
  logic [D_W-1:0]    x_k;
  logic [T_W-1:0]    x_n;
  logic [DATA_W-1:0] x_wdata;
  logic [BYTE_W-1:0] x_wmask;
  logic              gemm_start;
  logic              gemm_busy;
  logic              gemm_done;

  always #5 clk = ~clk;

  attention_score_seq #(.T(T), .DMAX(DMAX), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .D_len(D_len),
    .busy(busy), .done(done), .err(err),
    .tr_start(tr_start), .tr_busy(tr_busy), .tr_done(tr_done),
    .tr_b_re(tr_b_re), .tr_b_row(tr_b_row), .tr_b_col(tr_b_col),
    .tr_b_rdata(tr_b_rdata), .tr_b_rvalid(tr_b_rvalid),
    .x_we(x_we), .x_k(x_k), .x_n(x_n), .x_wdata(x_wdata), .x_wmask(x_wmask),
    .gemm_start(gemm_start), .gemm_busy(gemm_busy), .gemm_done(gemm_done)
  );

  typedef struct {
    int d_len;
    int trb;
    int trd;
    int lat;
    int gb;
    int gd;
    int exp_writes;
    int exp_done;
    int exp_err;
    int exp_trs;
    int exp_gs;
  } vec_t;

  typedef struct {
    int          k;
    int          n;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  // Partner-model timing knobs and the data salt for the B buffer.
  int          cfg_trb = 1;
  int          cfg_trd = 1;
  int          cfg_lat = 1;
  int          cfg_gb  = 1;
  int          cfg_gd  = 1;
  logic [31:0] salt    = 32'd0;
  logic        env_rst;

  // Monitor counters. They are never cleared; each check works on deltas.
  int  n_re = 0, n_trs = 0, n_gs = 0, n_done = 0, n_err = 0;
  int  n_busy = 0, n_nobusy = 0, n_overlap = 0;
  wr_t wq[$];

  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [31:0] b_word(input logic [31:0] row, input logic [31:0] col);
    return salt + row * 32'd16 + col;
  endfunction

  // Transpose engine: raises tr_busy once tr_start has been seen for cfg_trb
  // cycles, then pulses tr_done cfg_trd cycles later.
  initial begin : tr_model
    int cnt;
    int ph;
    cnt = 0; ph = 0; tr_busy = 1'b0; tr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (env_rst) begin
        tr_busy = 1'b0; tr_done = 1'b0; cnt = 0; ph = 0;
      end else begin
        tr_done = 1'b0;
        if (ph == 0) begin
          if (tr_start) begin
            cnt++;
            if (cnt >= cfg_trb) begin tr_busy = 1'b1; ph = 1; cnt = 0; end
          end else begin
            cnt = 0;
          end
        end else begin
          cnt++;
          if (cnt >= cfg_trd) begin tr_busy = 1'b0; tr_done = 1'b1; ph = 0; cnt = 0; end
        end
      end
    end
  end

  // GEMM engine: the same handshake shape, with its own delays.
  initial begin : gemm_model
    int cnt;
    int ph;
    cnt = 0; ph = 0; gemm_busy = 1'b0; gemm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (env_rst) begin
        gemm_busy = 1'b0; gemm_done = 1'b0; cnt = 0; ph = 0;
      end else begin
        gemm_done = 1'b0;
        if (ph == 0) begin
          if (gemm_start) begin
            cnt++;
            if (cnt >= cfg_gb) begin gemm_busy = 1'b1; ph = 1; cnt = 0; end
          end else begin
            cnt = 0;
          end
        end else begin
          cnt++;
          if (cnt >= cfg_gd) begin gemm_busy = 1'b0; gemm_done = 1'b1; ph = 0; cnt = 0; end
        end
      end
    end
  end

  // Transpose-B read port: returns the word cfg_lat cycles after the read.
  // rdata is garbage whenever rvalid is low, so capturing it at the wrong
  // time shows up in the write data. A new read that arrives while one is
  // still pending counts as an overlap.
  initial begin : b_model
    int          cnt;
    bit          pend;
    logic [31:0] pdata;
    cnt = 0; pend = 1'b0; pdata = '0; tr_b_rvalid = 1'b0; tr_b_rdata = '0;
    forever begin
      @(negedge clk);
      if (env_rst) begin
        pend = 1'b0; cnt = 0; tr_b_rvalid = 1'b0;
      end else begin
        tr_b_rvalid = 1'b0;
        tr_b_rdata  = $urandom;
        if (pend) begin
          cnt++;
          if (cnt >= cfg_lat) begin
            tr_b_rvalid = 1'b1; tr_b_rdata = pdata; pend = 1'b0;
          end
        end
        if (tr_b_re) begin
          if (pend) n_overlap++;
          pend = 1'b1; cnt = 0; pdata = b_word(tr_b_row, tr_b_col);
        end
      end
    end
  end

  // Monitor: records X writes and strobe activity once per cycle.
  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clk);
      if (x_we) begin
        w.k = int'(x_k); w.n = int'(x_n); w.d = x_wdata; w.m = x_wmask;
        wq.push_back(w);
      end
      n_re   += int'(tr_b_re);
      n_trs  += int'(tr_start);
      n_gs   += int'(gemm_start);
      n_done += int'(done);
      n_err  += int'(err);
      n_busy += int'(busy);
      if (!busy && (tr_start || tr_b_re || x_we || gemm_start || done)) n_nobusy++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic recover();
    rst = 1'b1; env_rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0; env_rst = 1'b0;
    tick();
  endtask

  // Runs one start request. The D_len input is scrambled after the start
  // edge, and when poke is set a second start is pulsed during GEMM_WAIT.
  // Both must be ignored. Afterwards the write list, the strobe counts and
  // the busy time are compared with the reference.
  task automatic applyStimulus(input vec_t v, input bit poke, input string tag);
    int  b_re, b_trs, b_gs, b_done, b_err, b_busy, b_nob, b_ovl, b_wq;
    int  nw, bad, exp_busy, cyc;
    bit  fin, prev_gs, poked;
    cfg_trb = v.trb; cfg_trd = v.trd; cfg_lat = v.lat; cfg_gb = v.gb; cfg_gd = v.gd;
    salt = $urandom;
    b_re = n_re; b_trs = n_trs; b_gs = n_gs; b_done = n_done; b_err = n_err;
    b_busy = n_busy; b_nob = n_nobusy; b_ovl = n_overlap; b_wq = wq.size();
    start = 1'b1; D_len = 16'(v.d_len);
    tick();
    start = 1'b0; D_len = 16'($urandom);
    fin = 1'b0; prev_gs = 1'b0; poked = 1'b0;
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      tick();
      start = 1'b0;
      if ((n_done != b_done) || (n_err != b_err) || (!busy && cyc > 2)) begin
        fin = 1'b1;
      end else if (poke && !poked && prev_gs && !gemm_start && busy && !done) begin
        start = 1'b1; D_len = 16'd2; poked = 1'b1;
      end
      prev_gs = gemm_start;
    end
    start = 1'b0;
    if (!fin) begin
      checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
      recover();
      return;
    end
    repeat (4) tick();
    nw  = wq.size() - b_wq;
    bad = 0;
    for (int i = 0; i < v.exp_writes && i < nw; i++) begin
      int kk, nn;
      kk = i / T; nn = i % T;
      if (wq[b_wq + i].k != kk || wq[b_wq + i].n != nn ||
          wq[b_wq + i].d !== salt + 32'(kk * 16 + nn) || wq[b_wq + i].m !== 4'hF) bad++;
    end
    exp_busy = (v.exp_err != 0) ? 0 :
               v.trb + v.trd + v.d_len * T * (v.lat + 2) + v.gb + v.gd + 1;
    checkOutput({tag, "_writes"},    64'(nw),                64'(v.exp_writes));
    checkOutput({tag, "_wcontent"},  64'(bad),               64'd0);
    checkOutput({tag, "_reads"},     64'(n_re - b_re),       64'(v.exp_writes));
    checkOutput({tag, "_done"},      64'(n_done - b_done),   64'(v.exp_done));
    checkOutput({tag, "_err"},       64'(n_err - b_err),     64'(v.exp_err));
    checkOutput({tag, "_trstart"},   64'(n_trs - b_trs),     64'(v.exp_trs));
    checkOutput({tag, "_gemmstart"}, 64'(n_gs - b_gs),       64'(v.exp_gs));
    checkOutput({tag, "_busycyc"},   64'(n_busy - b_busy),   64'(exp_busy));
    checkOutput({tag, "_overlap"},   64'(n_overlap - b_ovl), 64'd0);
    checkOutput({tag, "_nobusy"},    64'(n_nobusy - b_nob),  64'd0);
    checkOutput({tag, "_idle_end"},  64'(busy),              64'd0);
  endtask

  // Waits, with a bound, until the ready flag set by the caller's polling
  // goes high.
  task automatic waitFor(input int which, input int b_re, input int b_gs, input int b_done, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      tick();
      if (which == 0) ok = ((n_re - b_re) == 5) && !tr_b_re && busy;
      else            ok = ((n_gs - b_gs) >= 1) && !gemm_start && busy && (n_done == b_done);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    bit   ok;
    int   b_re, b_gs, b_done, b_wq, b_trs;
    rst = 1'b1; env_rst = 1'b1; start = 1'b0; abort = 1'b0; D_len = 16'd0;
    repeat (3) tick();
    checkOutput("reset_strobes",
                64'({busy, done, err, tr_start, tr_b_re, x_we, gemm_start}), 64'd0);
    checkOutput("reset_rowcol", {tr_b_row, tr_b_col}, 64'd0);
    checkOutput("reset_xport",  64'({x_k, x_n, x_wmask, x_wdata}), 64'd0);
    rst = 1'b0; env_rst = 1'b0;
    tick();

    //            D  trb trd lat gb gd  wr done err trs gs
    vecs[0] = '{4,     1,  5,  1, 1, 3, 16,  1,  0,  1, 1};
    vecs[1] = '{0,     1,  1,  1, 1, 1,  0,  0,  1,  0, 0};
    vecs[2] = '{9,     1,  1,  1, 1, 1,  0,  0,  1,  0, 0};
    vecs[3] = '{8,     1,  5,  3, 1, 3, 32,  1,  0,  1, 1};
    vecs[4] = '{1,     4,  2,  1, 2, 4,  4,  1,  0,  4, 2};
    vecs[5] = '{65535, 1,  1,  1, 1, 1,  0,  0,  1,  0, 0};
    vecs[6] = '{2,     2,  1,  2, 3, 1,  8,  1,  0,  2, 3};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], (i == 4), $sformatf("vec%0d", i));
    end

    // Abort during RD_WAIT of the fifth element, then a clean D_len=2 run.
    cfg_trb = 1; cfg_trd = 2; cfg_lat = 3; cfg_gb = 1; cfg_gd = 2; salt = $urandom;
    b_re = n_re; b_gs = n_gs; b_done = n_done; b_wq = wq.size();
    start = 1'b1; D_len = 16'd4;
    tick();
    start = 1'b0;
    waitFor(0, b_re, b_gs, b_done, ok);
    checkOutput("abort_reach_rdwait", 64'(ok), 64'd1);
    if (ok) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_strobes",
                  64'({busy, done, err, tr_start, tr_b_re, x_we, gemm_start}), 64'd0);
      checkOutput("abort_writes_so_far", 64'(wq.size() - b_wq), 64'd4);
      repeat (8) tick();
      checkOutput("abort_no_done",  64'(n_done - b_done), 64'd0);
      checkOutput("abort_no_more",  64'((wq.size() - b_wq) + (n_re - b_re) + (n_gs - b_gs)), 64'd9);
      v = '{2, 1, 2, 1, 1, 2, 8, 1, 0, 1, 1};
      applyStimulus(v, 1'b0, "post_abort");
    end else begin
      recover();
    end

    // Reset during GEMM_WAIT. The GEMM model is left running, so its late
    // gemm_done arrives while the sequencer is idle.
    cfg_trb = 1; cfg_trd = 2; cfg_lat = 1; cfg_gb = 1; cfg_gd = 6; salt = $urandom | 32'h1;
    b_re = n_re; b_gs = n_gs; b_done = n_done;
    start = 1'b1; D_len = 16'd1;
    tick();
    start = 1'b0;
    waitFor(1, b_re, b_gs, b_done, ok);
    checkOutput("rst_reach_gemmwait", 64'(ok), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_strobes",
                64'({busy, done, err, tr_start, tr_b_re, x_we, gemm_start}), 64'd0);
    checkOutput("rst_mid_rowcol", {tr_b_row, tr_b_col}, 64'd0);
    checkOutput("rst_mid_xport",  64'({x_k, x_n, x_wmask, x_wdata}), 64'd0);
    rst = 1'b0;
    b_done = n_done; b_trs = n_trs; b_re = n_re; b_gs = n_gs; b_wq = wq.size();
    repeat (10) tick();
    checkOutput("rst_no_done", 64'(n_done - b_done), 64'd0);
    checkOutput("rst_no_strobes",
                64'((n_trs - b_trs) + (n_re - b_re) + (n_gs - b_gs) + (wq.size() - b_wq)), 64'd0);
    checkOutput("rst_idle", 64'(busy), 64'd0);
    recover();

    // Randomised runs, with an occasional out-of-range head dimension.
    for (int r = 0; r < 16; r++) begin
      bit valid;
      v.trb = $urandom_range(1, 4); v.trd = $urandom_range(1, 4);
      v.lat = $urandom_range(1, 4); v.gb  = $urandom_range(1, 4);
      v.gd  = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin
        v.d_len = ($urandom_range(0, 1) == 0) ? 0 : DMAX + 1 + $urandom_range(0, 100);
      end else begin
        v.d_len = $urandom_range(1, DMAX);
      end
      valid        = (v.d_len >= 1) && (v.d_len <= DMAX);
      v.exp_writes = valid ? v.d_len * T : 0;
      v.exp_done   = valid ? 1 : 0;
      v.exp_err    = valid ? 0 : 1;
      v.exp_trs    = valid ? v.trb : 0;
      v.exp_gs     = valid ? v.gb : 0;
      applyStimulus(v, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
